// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic multiplier:
// FSM state encodings, a width helper and the output narrowing function.
package systolic_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FEED  = 3'd1;
    localparam state_t S_FLUSH = 3'd2;
    localparam state_t S_OUT   = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    // Never returns less than 1 so single-entry ranges still get a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Caller keeps the low out_width bits; with sat=0 that is a plain wrap.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] value,
                                                      input int out_width,
                                                      input logic sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sat && (value > hi)) return hi;
        if (sat && (value < lo)) return lo;
        return value;
    endfunction

endpackage

// File: rtl/systolic_array_stream_pe.sv
// One output-stationary processing element: forwards A right and B down
// one cycle later while accumulating their signed product in place.
module systolic_pe_os #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] a_next,
    output logic signed [DATA_WIDTH-1:0] b_next,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    logic signed [PROD_WIDTH-1:0] prod;

    assign prod = PROD_WIDTH'(a) * PROD_WIDTH'(b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_next <= '0;
            b_next <= '0;
            acc    <= '0;
        end else begin
            a_next <= a;
            b_next <= b;
            if (clear)
                acc <= '0;
            else if (enable)
                acc <= acc + {{(ACC_WIDTH - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
        end
    end

endmodule

// File: rtl/systolic_array_stream.sv
// Streaming NxN output-stationary matrix multiplier: skews operand beats into a
// PE mesh, flushes the wavefront, then emits result rows over valid/ready.
module systolic_array_stream
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_K      = 16,
    parameter int ACC_WIDTH  = 20,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [clog2(MAX_K+1)-1:0]          k_len,
    input  logic                               cfg_accum,
    input  logic                               cfg_sat,
    output logic                               busy,
    output logic                               done,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   in_a_col,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   in_b_row,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [clog2(ARRAY_SIZE)-1:0]       out_row_idx,
    output logic [ARRAY_SIZE*OUT_WIDTH-1:0]    out_row
);

    localparam int N  = ARRAY_SIZE;
    localparam int KW = clog2(MAX_K + 1);
    localparam int RW = clog2(N);
    localparam int FW = clog2(2 * N);

    state_t          state;
    logic [KW-1:0]   k_reg;
    logic            sat_reg;
    logic [KW-1:0]   beat_cnt;
    logic [FW-1:0]   flush_cnt;
    logic [RW-1:0]   row_idx;

    logic            in_fire;
    logic            acc_clear;
    logic            acc_enable;

    logic [N-1:0][N:0][DATA_WIDTH-1:0] a_bus;
    logic [N:0][N-1:0][DATA_WIDTH-1:0] b_bus;
    logic [N-1:0][N-1:0][ACC_WIDTH-1:0] acc_bus;

    logic                 unused_tail;
    logic signed [63:0]   wide;

    assign in_ready    = (state == S_FEED);
    assign out_valid   = (state == S_OUT);
    assign busy        = (state == S_FEED) || (state == S_FLUSH) || (state == S_OUT);
    assign done        = (state == S_DONE);
    assign out_row_idx = row_idx;
    assign in_fire     = in_valid && in_ready;
    assign acc_clear   = (state == S_IDLE) && start && !cfg_accum;
    assign acc_enable  = (state == S_FEED) || (state == S_FLUSH);

    // Control: FLUSH runs 2N-1 cycles so the last beat reaches PE(N-1,N-1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            k_reg     <= '0;
            sat_reg   <= 1'b0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_reg    <= k_len;
                        sat_reg  <= cfg_sat;
                        beat_cnt <= '0;
                        row_idx  <= '0;
                        state    <= (k_len == '0) ? S_OUT : S_FEED;
                    end
                end
                S_FEED: begin
                    if (in_fire) begin
                        beat_cnt <= beat_cnt + KW'(1);
                        if ((beat_cnt + KW'(1)) == k_reg) begin
                            flush_cnt <= '0;
                            state     <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == FW'(2 * N - 2))
                        state <= S_OUT;
                    else
                        flush_cnt <= flush_cnt + FW'(1);
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (row_idx == RW'(N - 1)) begin
                            row_idx <= '0;
                            state   <= S_DONE;
                        end else begin
                            row_idx <= row_idx + RW'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Lane i is delayed i cycles so operands of one beat meet on the anti-diagonal.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic signed [DATA_WIDTH-1:0] a_feed;
        logic signed [DATA_WIDTH-1:0] b_feed;

        assign a_feed = in_fire ? in_a_col[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign b_feed = in_fire ? in_b_row[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

        if (gi == 0) begin : g_direct
            assign a_bus[0][0] = a_feed;
            assign b_bus[0][0] = b_feed;
        end else begin : g_delay
            logic signed [DATA_WIDTH-1:0] a_dly [gi];
            logic signed [DATA_WIDTH-1:0] b_dly [gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < gi; d++) begin
                        a_dly[d] <= '0;
                        b_dly[d] <= '0;
                    end
                end else begin
                    a_dly[0] <= a_feed;
                    b_dly[0] <= b_feed;
                    for (int d = 1; d < gi; d++) begin
                        a_dly[d] <= a_dly[d-1];
                        b_dly[d] <= b_dly[d-1];
                    end
                end
            end

            assign a_bus[gi][0] = a_dly[gi-1];
            assign b_bus[0][gi] = b_dly[gi-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            systolic_pe_os #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk    (clk),
                .rst    (rst),
                .clear  (acc_clear),
                .enable (acc_enable),
                .a      (a_bus[gi][gj]),
                .b      (b_bus[gi][gj]),
                .a_next (a_bus[gi][gj+1]),
                .b_next (b_bus[gi+1][gj]),
                .acc    (acc_bus[gi][gj])
            );
        end
    end

    // Operands leaving the right and bottom edges of the mesh go nowhere.
    always_comb begin
        unused_tail = 1'b0;
        for (int i = 0; i < N; i++)
            unused_tail = unused_tail ^ (^a_bus[i][N]) ^ (^b_bus[N][i]);
    end

    always_comb begin
        out_row = '0;
        wide    = '0;
        if (state == S_OUT) begin
            for (int j = 0; j < N; j++) begin
                wide = {{(64 - ACC_WIDTH){acc_bus[row_idx][j][ACC_WIDTH-1]}}, acc_bus[row_idx][j]};
                out_row[j*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(sat_narrow(wide, OUT_WIDTH, sat_reg));
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_stream.sv
// Scoreboard bench for systolic_array_stream: a reference matrix model pushes
// expected rows at run start; rows captured from the DUT are popped against them.
module tb_systolic_array_stream;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int MAX_K = 16;
    localparam int AW    = 20;
    localparam int OW    = 16;
    localparam int KW    = 5;
    localparam int RW    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [KW-1:0]     k_len;
    logic              cfg_accum;
    logic              cfg_sat;
    logic              busy;
    logic              done;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_a_col;
    logic [N*DW-1:0]   in_b_row;
    logic              out_valid;
    logic              out_ready;
    logic [RW-1:0]     out_row_idx;
    logic [N*OW-1:0]   out_row;

    int vectors     = 0;
    int miscompares = 0;

    int     a_mat [N][MAX_K];
    int     b_mat [MAX_K][N];
    longint model_acc [N][N];

    logic [N*OW-1:0] exp_row [$];
    int              exp_idx [$];
    logic [N*OW-1:0] obs_row [$];
    int              obs_idx [$];

    systolic_array_stream #(
        .ARRAY_SIZE (N),
        .DATA_WIDTH (DW),
        .MAX_K      (MAX_K),
        .ACC_WIDTH  (AW),
        .OUT_WIDTH  (OW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .cfg_accum   (cfg_accum),
        .cfg_sat     (cfg_sat),
        .busy        (busy),
        .done        (done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a_col    (in_a_col),
        .in_b_row    (in_b_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row_idx (out_row_idx),
        .out_row     (out_row)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic fill_const(input int av, input int bv);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < MAX_K; k++) begin
                a_mat[i][k] = av;
                b_mat[k][i] = bv;
            end
    endtask

    task automatic fill_identity();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < MAX_K; k++) begin
                a_mat[i][k] = (i == k) ? 1 : 0;
                b_mat[k][i] = k * N + i + 1;
            end
    endtask

    // Reference model update plus expected-row push, then the start pulse.
    task automatic start_run(input int k, input bit accum, input bit sat);
        logic [N*OW-1:0] row;
        longint v;
        longint hi;
        hi = (64'sd1 <<< (OW - 1)) - 1;
        if (!accum)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) model_acc[i][j] = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int kk = 0; kk < k; kk++) model_acc[i][j] += a_mat[i][kk] * b_mat[kk][j];
        for (int i = 0; i < N; i++) begin
            row = '0;
            for (int j = 0; j < N; j++) begin
                v = model_acc[i][j];
                if (sat && v > hi) v = hi;
                if (sat && v < -hi - 1) v = -hi - 1;
                row[j*OW +: OW] = v[OW-1:0];
            end
            exp_row.push_back(row);
            exp_idx.push_back(i);
        end
        @(negedge clk);
        start = 1'b1; k_len = KW'(k); cfg_accum = accum; cfg_sat = sat;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int beats, input int bubble_pct, output bit timed_out);
        int sent = 0;
        int cycles = 0;
        timed_out = 1'b0;
        while (sent < beats) begin
            @(negedge clk);
            in_valid = (int'($urandom_range(99)) >= bubble_pct);
            for (int i = 0; i < N; i++) begin
                in_a_col[i*DW +: DW] = in_valid ? DW'(a_mat[i][first+sent]) : DW'($urandom);
                in_b_row[i*DW +: DW] = in_valid ? DW'(b_mat[first+sent][i]) : DW'($urandom);
            end
            if (in_valid && in_ready) sent++;
            cycles++;
            if (cycles > 1000) begin
                timed_out = 1'b1;
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int rows, input int stall_row, input int stall_len,
                           output int first_wait, output bit done_ok,
                           output bit stable_ok, output bit timed_out);
        int got = 0;
        int cycles = 0;
        int stall_left;
        bit seen_valid = 1'b0;
        bit snapped = 1'b0;
        logic [N*OW-1:0] snap_row;
        logic [RW-1:0]   snap_idx;
        logic            done1;
        logic            busy1;
        stall_left = stall_len;
        first_wait = 0; done_ok = 1'b0; stable_ok = 1'b1; timed_out = 1'b0;
        while (got < rows) begin
            @(negedge clk);
            if (out_valid && got == stall_row && stall_left > 0) begin
                out_ready = 1'b0;
                if (!snapped) begin
                    snap_row = out_row;
                    snap_idx = out_row_idx;
                    snapped  = 1'b1;
                end else if (out_row !== snap_row || out_row_idx !== snap_idx) begin
                    stable_ok = 1'b0;
                end
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready && snapped && got == stall_row &&
                (out_row !== snap_row || out_row_idx !== snap_idx))
                stable_ok = 1'b0;
            if (!out_valid && !seen_valid) first_wait++;
            if (out_valid) seen_valid = 1'b1;
            if (out_valid && out_ready) begin
                obs_row.push_back(out_row);
                obs_idx.push_back(int'(out_row_idx));
                got++;
            end
            cycles++;
            if (cycles > 500) begin
                timed_out = 1'b1;
                break;
            end
        end
        @(negedge clk);
        done1 = done; busy1 = busy;
        out_ready = 1'b0;
        @(negedge clk);
        done_ok = !timed_out && done1 && !busy1 && !done && !busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, in_ready, out_valid, out_row_idx, out_row} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0",
                     {busy, done, in_ready, out_valid, out_row_idx, out_row});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, in_ready, out_valid, out_row_idx, out_row} !== '0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got %h, expected 0",
                     {busy, done, in_ready, out_valid, out_row_idx, out_row});
        end
    endtask

    task automatic test_identity();
        bit to_f, to_c, dok, sok;
        int fw;
        logic [N*OW-1:0] er;
        int ei;
        fill_identity();
        start_run(4, 1'b0, 1'b1);
        feed(0, 4, 0, to_f);
        collect(N, -1, 0, fw, dok, sok, to_c);
        vectors++;
        if (to_f || to_c) begin
            miscompares++;
            $display("[TB] FAIL identity_timeout: feed %0d collect %0d, expected 0 0", to_f, to_c);
        end
        // Last beat in cycle t, collector starts sampling at t+2, first row at t+2N.
        vectors++;
        if (fw !== 2 * N - 2) begin
            miscompares++;
            $display("[TB] FAIL identity_latency: got %0d idle samples, expected %0d", fw, 2 * N - 2);
        end
        vectors++;
        if (dok !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL identity_done_pulse: got %0d, expected 1", dok);
        end
        while (obs_row.size() > 0) begin
            er = exp_row.pop_front(); ei = exp_idx.pop_front();
            vectors++;
            if (obs_row[0] !== er || obs_idx[0] !== ei) begin
                miscompares++;
                $display("[TB] FAIL identity_row: got idx %0d %h, expected idx %0d %h",
                         obs_idx[0], obs_row[0], ei, er);
            end
            void'(obs_row.pop_front()); void'(obs_idx.pop_front());
        end
    endtask

    task automatic test_saturation();
        bit to_f, to_c, dok, sok;
        int fw;
        int n = 0;
        logic [N*OW-1:0] er;
        logic [N*OW-1:0] ek;
        int ei;
        fill_const(127, 127);
        start_run(16, 1'b0, 1'b1);
        feed(0, 16, 0, to_f);
        collect(N, -1, 0, fw, dok, sok, to_c);
        start_run(16, 1'b0, 1'b0);
        feed(0, 16, 0, to_f);
        collect(N, -1, 0, fw, dok, sok, to_c);
        while (obs_row.size() > 0) begin
            er = exp_row.pop_front(); ei = exp_idx.pop_front();
            ek = (n < N) ? {N{16'h7FFF}} : {N{16'hF010}};
            vectors++;
            if (obs_row[0] !== er || obs_row[0] !== ek || obs_idx[0] !== ei) begin
                miscompares++;
                $display("[TB] FAIL sat_wrap_row%0d: got idx %0d %h, expected idx %0d %h",
                         n, obs_idx[0], obs_row[0], ei, ek);
            end
            void'(obs_row.pop_front()); void'(obs_idx.pop_front());
            n++;
        end
        vectors++;
        if (n !== 2 * N || to_c) begin
            miscompares++;
            $display("[TB] FAIL sat_row_count: got %0d rows, expected %0d", n, 2 * N);
        end
    endtask

    task automatic test_neg_corner();
        bit to_f, to_c, dok, sok;
        int fw;
        logic [N*OW-1:0] er;
        int ei;
        fill_const(0, 0);
        a_mat[0][0] = -128;
        b_mat[0][0] = -128;
        start_run(1, 1'b0, 1'b1);
        feed(0, 1, 0, to_f);
        collect(N, -1, 0, fw, dok, sok, to_c);
        vectors++;
        if (obs_row.size() == 0 || obs_row[0][OW-1:0] !== 16'h4000) begin
            miscompares++;
            $display("[TB] FAIL neg_corner_c00: got %h, expected 4000",
                     (obs_row.size() > 0) ? obs_row[0][OW-1:0] : 16'hxxxx);
        end
        while (obs_row.size() > 0) begin
            er = exp_row.pop_front(); ei = exp_idx.pop_front();
            vectors++;
            if (obs_row[0] !== er || obs_idx[0] !== ei) begin
                miscompares++;
                $display("[TB] FAIL neg_corner_row: got idx %0d %h, expected idx %0d %h",
                         obs_idx[0], obs_row[0], ei, er);
            end
            void'(obs_row.pop_front()); void'(obs_idx.pop_front());
        end
    endtask

    task automatic test_accumulate();
        bit to_f, to_c, dok, sok;
        int fw;
        int n = 0;
        logic [N*OW-1:0] er;
        logic [N*OW-1:0] ek;
        int ei;
        fill_const(1, 3);
        start_run(2, 1'b0, 1'b1); feed(0, 2, 0, to_f); collect(N, -1, 0, fw, dok, sok, to_c);
        start_run(2, 1'b1, 1'b1); feed(0, 2, 0, to_f); collect(N, -1, 0, fw, dok, sok, to_c);
        start_run(2, 1'b0, 1'b1); feed(0, 2, 0, to_f); collect(N, -1, 0, fw, dok, sok, to_c);
        while (obs_row.size() > 0) begin
            er = exp_row.pop_front(); ei = exp_idx.pop_front();
            ek = (n >= N && n < 2 * N) ? {N{16'd12}} : {N{16'd6}};
            vectors++;
            if (obs_row[0] !== er || obs_row[0] !== ek || obs_idx[0] !== ei) begin
                miscompares++;
                $display("[TB] FAIL accumulate_row%0d: got idx %0d %h, expected idx %0d %h",
                         n, obs_idx[0], obs_row[0], ei, ek);
            end
            void'(obs_row.pop_front()); void'(obs_idx.pop_front());
            n++;
        end
    endtask

    task automatic test_backpressure();
        bit to_f, to_c, dok, sok;
        int fw;
        logic [N*OW-1:0] er;
        int ei;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < MAX_K; k++) begin
                a_mat[i][k] = int'($urandom_range(255)) - 128;
                b_mat[k][i] = int'($urandom_range(255)) - 128;
            end
        start_run(8, 1'b0, 1'b1);
        feed(0, 8, 40, to_f);
        collect(N, 1, 5, fw, dok, sok, to_c);
        vectors++;
        if (sok !== 1'b1 || to_f || to_c || dok !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL backpressure_flags: stable %0d done %0d timeouts %0d/%0d, expected 1 1 0/0",
                     sok, dok, to_f, to_c);
        end
        while (obs_row.size() > 0) begin
            er = exp_row.pop_front(); ei = exp_idx.pop_front();
            vectors++;
            if (obs_row[0] !== er || obs_idx[0] !== ei) begin
                miscompares++;
                $display("[TB] FAIL backpressure_row: got idx %0d %h, expected idx %0d %h",
                         obs_idx[0], obs_row[0], ei, er);
            end
            void'(obs_row.pop_front()); void'(obs_idx.pop_front());
        end
    endtask

    task automatic test_k_zero();
        bit to_c, dok, sok;
        int fw;
        logic [N*OW-1:0] er;
        int ei;
        start_run(0, 1'b0, 1'b1);
        collect(N, -1, 0, fw, dok, sok, to_c);
        vectors++;
        if (dok !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL k_zero_done: got %0d, expected 1", dok);
        end
        while (obs_row.size() > 0) begin
            er = exp_row.pop_front(); ei = exp_idx.pop_front();
            vectors++;
            if (obs_row[0] !== er || er !== '0 || obs_idx[0] !== ei) begin
                miscompares++;
                $display("[TB] FAIL k_zero_row: got idx %0d %h, expected idx %0d 0",
                         obs_idx[0], obs_row[0], ei);
            end
            void'(obs_row.pop_front()); void'(obs_idx.pop_front());
        end
    endtask

    task automatic test_start_ignored();
        bit to_f, to_c, dok, sok;
        int fw;
        logic [N*OW-1:0] er;
        int ei;
        fill_identity();
        start_run(4, 1'b0, 1'b1);
        feed(0, 2, 0, to_f);
        @(negedge clk);
        start = 1'b1; k_len = '0; cfg_accum = 1'b0; cfg_sat = 1'b0;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL start_ignored_state: busy %0d in_ready %0d, expected 1 1", busy, in_ready);
        end
        feed(2, 2, 0, to_f);
        collect(N, -1, 0, fw, dok, sok, to_c);
        while (obs_row.size() > 0) begin
            er = exp_row.pop_front(); ei = exp_idx.pop_front();
            vectors++;
            if (obs_row[0] !== er || obs_idx[0] !== ei) begin
                miscompares++;
                $display("[TB] FAIL start_ignored_row: got idx %0d %h, expected idx %0d %h",
                         obs_idx[0], obs_row[0], ei, er);
            end
            void'(obs_row.pop_front()); void'(obs_idx.pop_front());
        end
    endtask

    task automatic test_reset_mid_feed();
        bit to_f, to_c, dok, sok;
        int fw;
        logic [N*OW-1:0] er;
        int ei;
        fill_identity();
        start_run(4, 1'b0, 1'b1);
        feed(0, 2, 0, to_f);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, in_ready, out_valid, out_row_idx, out_row} !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_feed_reset_outputs: got %h, expected 0",
                     {busy, done, in_ready, out_valid, out_row_idx, out_row});
        end
        @(negedge clk);
        rst = 1'b0;
        exp_row.delete();
        exp_idx.delete();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) model_acc[i][j] = 0;
        // Accumulate mode after reset exposes any accumulator or skew residue.
        start_run(4, 1'b1, 1'b1);
        feed(0, 4, 0, to_f);
        collect(N, -1, 0, fw, dok, sok, to_c);
        while (obs_row.size() > 0) begin
            er = exp_row.pop_front(); ei = exp_idx.pop_front();
            vectors++;
            if (obs_row[0] !== er || obs_idx[0] !== ei) begin
                miscompares++;
                $display("[TB] FAIL post_reset_row: got idx %0d %h, expected idx %0d %h",
                         obs_idx[0], obs_row[0], ei, er);
            end
            void'(obs_row.pop_front()); void'(obs_idx.pop_front());
        end
        vectors++;
        if (exp_row.size() != 0 || to_c) begin
            miscompares++;
            $display("[TB] FAIL post_reset_count: %0d rows missing, expected 0", exp_row.size());
        end
    endtask

    initial begin
        start = 1'b0; k_len = '0; cfg_accum = 1'b0; cfg_sat = 1'b0;
        in_valid = 1'b0; in_a_col = '0; in_b_row = '0; out_ready = 1'b0;
        test_reset();
        test_identity();
        test_saturation();
        test_neg_corner();
        test_accumulate();
        test_backpressure();
        test_k_zero();
        test_start_ignored();
        test_reset_mid_feed();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_array_stream.md
Name: systolic_array_stream

Overview:
- Parametrised output-stationary systolic matrix multiplier. Computes C = A(NxK) * B(KxN) for N = ARRAY_SIZE and a runtime K up to MAX_K.
- Operands stream in through a valid/ready handshake: one column of A and one row of B per beat. Internal skew registers and per-PE accumulators replace buffered weight preload.
- Results leave as a valid/ready row stream, with optional saturation and accumulate-across-runs (tiling) mode.
- Sits between the operand memory readers and the result writer in the matrix-multiplier datapath.

Parameters:
- ARRAY_SIZE, 4: N, PE grid is NxN.
- DATA_WIDTH, 8: signed operand width.
- MAX_K, 16: maximum inner dimension per run.
- ACC_WIDTH, 20: signed accumulator width. Must be >= 2*DATA_WIDTH + clog2(MAX_K).
- OUT_WIDTH, 16: signed width of each output element.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  run request; sampled in IDLE only.
- k_len  in  clog2(MAX_K+1)  inner dimension K; latched on start.
- cfg_accum  in  1  1 = keep accumulators from the previous run; latched on start.
- cfg_sat  in  1  1 = saturate output, 0 = truncate; latched on start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at run end.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid & in_ready.
- in_a_col  in  N*DATA_WIDTH  A[i][k]; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_b_row  in  N*DATA_WIDTH  B[k][j]; element j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result row valid.
- out_ready  in  1  result row consumed when out_valid & out_ready.
- out_row_idx  out  clog2(N)  row index r of out_row.
- out_row  out  N*OUT_WIDTH  C[r][j]; element j at bits [j*OUT_WIDTH +: OUT_WIDTH].

Behaviour:
- Reset (asynchronous, any state, including mid-run):
  - State returns to IDLE.
  - Accumulators, skew registers, PE pipes and counters clear to 0.
  - busy, done, in_ready, out_valid, out_row_idx and out_row are all 0.
- States: IDLE -> FEED -> FLUSH -> OUT -> DONE -> IDLE.
- IDLE:
  - start=1 latches k_len, cfg_accum and cfg_sat, and sets busy the next cycle.
  - If cfg_accum=0, all accumulators clear on that edge.
  - If k_len=0, go directly to OUT; otherwise go to FEED.
  - start outside IDLE is ignored.
- FEED:
  - in_ready=1. The beat counter increments per accepted beat.
  - After the k_len-th accepted beat, go to FLUSH; in_ready drops in the same cycle as that handshake's following edge.
  - Cycles without a handshake inject zeros into both streams (bubble). Results are unaffected.
- Skew and propagation:
  - A element i is delayed i cycles and B element j is delayed j cycles.
  - A moves right one PE per cycle; B moves down one PE per cycle.
  - An operand pair accepted at cycle t meets in PE(i,j) at t+i+j. The accumulator updates at the following edge: acc += a*b, full-precision signed product sign-extended to ACC_WIDTH.
- FLUSH: fixed 2*N-1 cycles. After it, all accumulators are final. Then go to OUT.
- OUT:
  - out_valid=1, presenting row out_row_idx = 0..N-1.
  - Data is held stable while out_ready=0.
  - The index advances on each handshake. After row N-1 is accepted, go to DONE.
- Output conversion per element:
  - cfg_sat=1: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - cfg_sat=0: low OUT_WIDTH bits (two's-complement wrap).
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Accumulators persist after the run, for use by cfg_accum=1 on the next run.
- No overflow inside the accumulator for K <= MAX_K, given the ACC_WIDTH rule.
- Latency: last accepted beat to first out_valid = 2*N cycles.

Decomposition:
- Package systolic_pkg:
  - state enum (IDLE, FEED, FLUSH, OUT, DONE).
  - saturating-narrow function (ACC_WIDTH -> OUT_WIDTH).
  - clog2 helper.
- Sub-module systolic_pe_os holds one PE: registered A/B pass-through, accumulate enable, synchronous clear, async reset.

Test Plan:
- Identity: N=4, K=4, A=I, B=1..16 row-major, cfg_sat=1 -> four rows equal B rows, out_row_idx 0..3, done pulse one cycle after row 3 handshake.
- Signs and saturation: A and B all 127, K=16.
  - cfg_sat=1 -> every element 32767.
  - cfg_sat=0 -> every element -4080 (258064 mod 2^16).
  - Separately, A[0][0]=B[0][0]=-128, K=1 -> C[0][0]=16384.
- Accumulate: run K=2 with A all 1 and B all 3 -> all 6. Rerun identical data with cfg_accum=1 -> all 12. Rerun with cfg_accum=0 -> all 6.
- Backpressure: random in_valid gaps and out_ready low for 5 cycles mid-OUT -> results identical to the no-stall run; out_row stable during the stall; no duplicate or skipped rows.
- Edge starts:
  - k_len=0, cfg_accum=0 -> 4 zero rows and done.
  - start pulsed while busy -> ignored.
- Reset mid-FEED after 2 beats -> all outputs 0 and IDLE. The next full identity run produces correct results with no residue.
